// File: rtl/reg_wr_arb_pkg.sv
// Shared definitions for the register write arbiter: FSM state encoding and
// a constant-foldable ceiling-log2 helper used for counter and index widths.
package reg_wr_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_LOCKED = 2'd1
    } arb_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/reg_wr_arb_rr_pick.sv
// Round-robin picker: grants the first set request found after 'last',
// wrapping N-1 -> 0, so the previous winner has lowest priority.
module rr_pick
    import reg_wr_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int LW = (clog2(N) > 0) ? clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic          any
);

    always_comb begin
        int  idx;
        logic found;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int j = 1; j <= N; j++) begin
            idx = (int'(last) + j) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        any = |req;
    end

endmodule

// File: rtl/reg_wr_arb.sv
// Shared control register with valid/ready write arbitration: class priority
// (starved > hipri > normal), round-robin within a class, and bounded burst locks.
module reg_wr_arb
    import reg_wr_arb_pkg::*;
#(
    parameter int                N_REQ      = 4,
    parameter int                WIDTH      = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL  = '0,
    parameter int                STARVE_LIM = 15,
    parameter int                LOCK_MAX   = 4,
    parameter int                LOCK_TMO   = 8,
    localparam int               SW         = (clog2(N_REQ) > 0) ? clog2(N_REQ) : 1
) (
    input  logic                   clkrst_core_clk,
    input  logic                   clkrst_core_rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]       req_hipri,
    input  logic [N_REQ-1:0]       req_lock,
    output logic [N_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]       q,
    output logic                   q_wr,
    output logic [SW-1:0]          q_src,
    output logic                   locked
);

    localparam int CW = clog2(STARVE_LIM + 1);
    localparam int BW = (clog2(LOCK_MAX + 1) > 0) ? clog2(LOCK_MAX + 1) : 1;
    localparam int IW = (clog2(LOCK_TMO + 1) > 0) ? clog2(LOCK_TMO + 1) : 1;

    arb_state_t       state;
    arb_state_t       state_next;
    logic [SW-1:0]    owner;
    logic [SW-1:0]    owner_next;
    logic [BW-1:0]    beats;
    logic [BW-1:0]    beats_next;
    logic [IW-1:0]    idle_cnt;
    logic [IW-1:0]    idle_next;
    logic [SW-1:0]    last;
    logic [CW-1:0]    wait_cnt [N_REQ];

    logic [N_REQ-1:0] starved;
    logic [N_REQ-1:0] hi;
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] gnt;
    logic             pick_any;
    logic             xfer;
    logic [SW-1:0]    xfer_idx;
    logic [BW-1:0]    beats_inc;
    logic [IW-1:0]    idle_inc;

    always_comb begin
        starved = '0;
        for (int i = 0; i < N_REQ; i++) begin
            starved[i] = req_valid[i] && (wait_cnt[i] == CW'(STARVE_LIM));
        end
        hi = req_valid & req_hipri;
    end

    // A lock narrows eligibility to the owner regardless of class, so
    // starvation can never preempt a burst.
    always_comb begin
        elig = '0;
        if (state == ARB_LOCKED) begin
            elig[owner] = req_valid[owner];
        end else if (|starved) begin
            elig = starved;
        end else if (|hi) begin
            elig = hi;
        end else begin
            elig = req_valid;
        end
    end

    rr_pick #(.N(N_REQ)) u_pick (
        .req  (elig),
        .last (last),
        .gnt  (gnt),
        .any  (pick_any)
    );

    assign req_ready = clkrst_core_rst_n ? gnt : '0;
    assign xfer      = pick_any && clkrst_core_rst_n;
    assign locked    = (state == ARB_LOCKED);
    assign beats_inc = beats + BW'(1);
    assign idle_inc  = idle_cnt + IW'(1);

    always_comb begin
        xfer_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                xfer_idx = SW'(i);
            end
        end
    end

    always_comb begin
        state_next = state;
        owner_next = owner;
        beats_next = beats;
        idle_next  = idle_cnt;
        case (state)
            ARB_IDLE: begin
                if (xfer && req_lock[xfer_idx] && (LOCK_MAX > 1)) begin
                    state_next = ARB_LOCKED;
                    owner_next = xfer_idx;
                    beats_next = BW'(1);
                    idle_next  = '0;
                end
            end
            ARB_LOCKED: begin
                if (xfer) begin
                    idle_next = '0;
                    if (!req_lock[owner] || (beats_inc >= BW'(LOCK_MAX))) begin
                        state_next = ARB_IDLE;
                    end else begin
                        beats_next = beats_inc;
                    end
                end else begin
                    idle_next = idle_inc;
                    if (idle_inc >= IW'(LOCK_TMO)) begin
                        state_next = ARB_IDLE;
                    end
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clkrst_core_clk) begin
        if (!clkrst_core_rst_n) begin
            state    <= ARB_IDLE;
            owner    <= '0;
            beats    <= '0;
            idle_cnt <= '0;
            last     <= SW'(N_REQ - 1);
            q        <= RESET_VAL;
            q_wr     <= 1'b0;
            q_src    <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            state    <= state_next;
            owner    <= owner_next;
            beats    <= beats_next;
            idle_cnt <= idle_next;
            q_wr     <= xfer;
            if (xfer) begin
                q     <= req_data[xfer_idx*WIDTH +: WIDTH];
                q_src <= xfer_idx;
                last  <= xfer_idx;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (!req_valid[i] || req_ready[i]) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] != CW'(STARVE_LIM)) begin
                    wait_cnt[i] <= wait_cnt[i] + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_wr_arb.sv
// Scoreboard bench for reg_wr_arb: directed scenarios then randomized traffic,
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_reg_wr_arb;

    localparam int         N  = 4;
    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'hA5;
    localparam int         SL = 3;
    localparam int         LM = 4;
    localparam int         LT = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_hipri;
    logic [N-1:0]   req_lock;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   q;
    logic           q_wr;
    logic [1:0]     q_src;
    logic           locked;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [W-1:0] data;
        int           src;
    } exp_t;
    exp_t sb_q[$];

    bit           m_locked = 1'b0;
    int           m_owner  = 0;
    int           m_beats  = 0;
    int           m_idle   = 0;
    int           m_last   = N - 1;
    int           m_wait[N] = '{default: 0};
    logic [W-1:0] m_q      = RV;
    bit           m_qwr    = 1'b0;
    int           m_src    = 0;

    reg_wr_arb #(
        .N_REQ(N), .WIDTH(W), .RESET_VAL(RV),
        .STARVE_LIM(SL), .LOCK_MAX(LM), .LOCK_TMO(LT)
    ) dut (
        .clkrst_core_clk   (clk),
        .clkrst_core_rst_n (rst_n),
        .req_valid         (req_valid),
        .req_data          (req_data),
        .req_hipri         (req_hipri),
        .req_lock          (req_lock),
        .req_ready         (req_ready),
        .q                 (q),
        .q_wr              (q_wr),
        .q_src             (q_src),
        .locked            (locked)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input logic rst, input logic [N-1:0] v, input logic [N-1:0] h,
                                  input logic [N-1:0] l, input logic [N*W-1:0] d);
        @(posedge clk);
        #1;
        rst_n     = rst;
        req_valid = v;
        req_hipri = h;
        req_lock  = l;
        req_data  = d;
    endtask

    // Reference model: classify every valid requester, keep the best class,
    // then scan from last+1; predictions feed both direct checks and the scoreboard.
    always @(negedge clk) begin
        logic [N-1:0] exp_ready;
        int cls[N];
        int top;
        int g;
        exp_ready = '0;
        g = -1;
        if (rst_n) begin
            if (m_locked) begin
                if (req_valid[m_owner]) g = m_owner;
            end else begin
                top = -1;
                for (int i = 0; i < N; i++) begin
                    if (!req_valid[i])          cls[i] = -1;
                    else if (m_wait[i] == SL)   cls[i] = 2;
                    else if (req_hipri[i])      cls[i] = 1;
                    else                        cls[i] = 0;
                    if (cls[i] > top) top = cls[i];
                end
                if (top >= 0) begin
                    for (int j = 1; j <= N; j++) begin
                        if (g < 0 && cls[(m_last + j) % N] == top) g = (m_last + j) % N;
                    end
                end
            end
            if (g >= 0) exp_ready[g] = 1'b1;
        end

        check_output("ready", 32'(req_ready), 32'(exp_ready));
        check_output("locked", 32'(locked), 32'(m_locked));
        check_output("q", 32'(q), 32'(m_q));
        check_output("q_wr", 32'(q_wr), 32'(m_qwr));
        check_output("q_src", 32'(q_src), 32'(m_src));

        if (!rst_n) begin
            m_locked = 1'b0;
            m_owner  = 0;
            m_beats  = 0;
            m_idle   = 0;
            m_last   = N - 1;
            m_q      = RV;
            m_qwr    = 1'b0;
            m_src    = 0;
            for (int i = 0; i < N; i++) m_wait[i] = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || i == g) m_wait[i] = 0;
                else if (m_wait[i] < SL)     m_wait[i] = m_wait[i] + 1;
            end
            m_qwr = (g >= 0);
            if (g >= 0) begin
                m_q    = req_data[g*W +: W];
                m_src  = g;
                m_last = g;
                sb_q.push_back('{data: req_data[g*W +: W], src: g});
            end
            if (!m_locked) begin
                if (g >= 0 && req_lock[g] && LM > 1) begin
                    m_locked = 1'b1;
                    m_owner  = g;
                    m_beats  = 1;
                    m_idle   = 0;
                end
            end else if (g >= 0) begin
                m_idle = 0;
                if (!req_lock[g]) begin
                    m_locked = 1'b0;
                end else begin
                    m_beats = m_beats + 1;
                    if (m_beats >= LM) m_locked = 1'b0;
                end
            end else begin
                m_idle = m_idle + 1;
                if (m_idle >= LT) m_locked = 1'b0;
            end
        end
    end

    // Monitor: every write the DUT presents must match the oldest predicted transfer.
    always @(negedge clk) begin
        exp_t e;
        if (q_wr === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("[TB] FAIL sb_unexpected: write q=%0h src=%0d with no predicted transfer at %0t",
                         q, q_src, $time);
            end else begin
                e = sb_q.pop_front();
                check_output("sb_data", 32'(q), 32'(e.data));
                check_output("sb_src", 32'(q_src), 32'(e.src));
            end
        end
    end

    initial begin
        logic [N-1:0] v;
        rst_n     = 1'b0;
        req_valid = 4'b0001;
        req_hipri = '0;
        req_lock  = '0;
        req_data  = 32'h0000_0011;

        $display("[TB] reset with requester 0 pending");
        apply_stimulus(1'b0, 4'b0001, 4'b0000, 4'b0000, 32'h0000_0011);
        apply_stimulus(1'b1, 4'b0001, 4'b0000, 4'b0000, 32'h0000_0011);
        apply_stimulus(1'b1, 4'b0000, 4'b0000, 4'b0000, 32'h0);

        $display("[TB] all requesters, normal priority");
        for (int c = 0; c < 6; c++) apply_stimulus(1'b1, 4'b1111, 4'b0000, 4'b0000, 32'h0403_0201);
        apply_stimulus(1'b1, 4'b0000, 4'b0000, 4'b0000, 32'h0);

        $display("[TB] hipri versus starving normal requester");
        for (int c = 0; c < 6; c++) apply_stimulus(1'b1, 4'b0110, 4'b0100, 4'b0000, 32'h0033_2200);
        apply_stimulus(1'b1, 4'b0000, 4'b0000, 4'b0000, 32'h0);

        $display("[TB] lock burst bounded by beat limit");
        for (int c = 0; c < 8; c++) apply_stimulus(1'b1, 4'b1001, 4'b0000, 4'b1000, {8'(8'h30 + c), 16'h0, 8'h0A});
        apply_stimulus(1'b1, 4'b0000, 4'b0000, 4'b0000, 32'h0);

        $display("[TB] lock dropped by owner idle timeout");
        apply_stimulus(1'b1, 4'b0011, 4'b0010, 4'b0010, 32'h0000_5B0C);
        for (int c = 0; c < 11; c++) apply_stimulus(1'b1, 4'b0001, 4'b0000, 4'b0000, 32'h0000_000D);
        apply_stimulus(1'b1, 4'b0000, 4'b0000, 4'b0000, 32'h0);

        $display("[TB] reset during lock with pending transfer");
        apply_stimulus(1'b1, 4'b1000, 4'b0000, 4'b1000, 32'h7E00_0000);
        apply_stimulus(1'b0, 4'b1001, 4'b0000, 4'b1000, 32'h7F00_0001);
        apply_stimulus(1'b1, 4'b0000, 4'b0000, 4'b0000, 32'h0);
        apply_stimulus(1'b1, 4'b0000, 4'b0000, 4'b0000, 32'h0);

        $display("[TB] randomized traffic");
        v = '0;
        for (int c = 0; c < 600; c++) begin
            logic [N-1:0] l;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) v[i] = ~v[i];
                l[i] = ($urandom_range(0, 3) == 0);
            end
            apply_stimulus(($urandom_range(0, 59) != 0), v, N'($urandom), l, $urandom);
        end

        for (int c = 0; c < 3; c++) apply_stimulus(1'b1, 4'b0000, 4'b0000, 4'b0000, 32'h0);
        @(negedge clk);
        #1;
        check_output("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
